// File: rtl/audio_sample_stream_buffer.sv
// Stereo PCM elastic buffer feeding the HDMI packet picker: FIFO, prefill gate,
// one output word per clk_audio edge, silence plus re-prime on underrun.
module audio_sample_stream_buffer #(
    parameter int unsigned AUDIO_BIT_WIDTH = 16,
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned PREFILL         = 8
) (
    input  logic                         clk_audio,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [AUDIO_BIT_WIDTH-1:0]   in_left,
    input  logic [AUDIO_BIT_WIDTH-1:0]   in_right,
    output logic [AUDIO_BIT_WIDTH-1:0]   audio_sample_word [1:0],
    output logic                         out_active,
    output logic [$clog2(DEPTH):0]       fill_level,
    output logic [15:0]                  underrun_count
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned FILL_W = AW + 1;
    localparam logic [AW:0] FULL_LVL    = FILL_W'(DEPTH);
    localparam logic [AW:0] PREFILL_LVL = FILL_W'(PREFILL);

    typedef enum logic {
        FILLING   = 1'b0,
        STREAMING = 1'b1
    } state_t;

    state_t state, state_next;

    logic [2*AUDIO_BIT_WIDTH-1:0] mem [DEPTH];
    logic [2*AUDIO_BIT_WIDTH-1:0] head;
    logic [AW-1:0]                wr_ptr, rd_ptr;
    logic [15:0]                  count_q;
    logic                         push, pop, underrun;

    assign in_ready       = (fill_level != FULL_LVL);
    assign head           = mem[rd_ptr];
    assign underrun_count = count_q;

    always_comb begin
        state_next = state;
        push       = in_valid && in_ready;
        pop        = 1'b0;
        underrun   = 1'b0;
        unique case (state)
            FILLING: begin
                if (fill_level >= PREFILL_LVL) state_next = STREAMING;
            end
            STREAMING: begin
                if (fill_level != '0) begin
                    pop = 1'b1;
                end else begin
                    underrun   = 1'b1;
                    state_next = FILLING;
                end
            end
            default: state_next = FILLING;
        endcase
    end

    // Storage carries no reset; only occupied slots are ever read.
    always_ff @(posedge clk_audio) begin
        if (push) mem[wr_ptr] <= {in_left, in_right};
    end

    always_ff @(posedge clk_audio) begin
        if (reset) begin
            state                <= FILLING;
            out_active           <= 1'b0;
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            fill_level           <= '0;
            count_q              <= '0;
            audio_sample_word[0] <= '0;
            audio_sample_word[1] <= '0;
        end else begin
            state      <= state_next;
            out_active <= (state_next == STREAMING);

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            if (push && !pop)      fill_level <= fill_level + 1'b1;
            else if (pop && !push) fill_level <= fill_level - 1'b1;

            if (pop) begin
                audio_sample_word[0] <= head[2*AUDIO_BIT_WIDTH-1:AUDIO_BIT_WIDTH];
                audio_sample_word[1] <= head[AUDIO_BIT_WIDTH-1:0];
            end else if (underrun) begin
                audio_sample_word[0] <= '0;
                audio_sample_word[1] <= '0;
            end

            if (underrun && count_q != '1) count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_audio_sample_stream_buffer.sv
// Bench for audio_sample_stream_buffer: prefill table plus a queue-based
// reference model compared every cycle across stream, underrun and backpressure runs.
module tb_audio_sample_stream_buffer;

    localparam int W = 16;

    logic         clk_audio = 1'b0;
    logic         reset     = 1'b1;
    logic         in_valid  = 1'b0;
    logic [W-1:0] in_left   = '0;
    logic [W-1:0] in_right  = '0;

    logic         ready_a, active_a, ready_b, active_b;
    logic [W-1:0] word_a [1:0];
    logic [W-1:0] word_b [1:0];
    logic [4:0]   fill_a, fill_b;
    logic [15:0]  count_a, count_b;

    always #5 clk_audio = ~clk_audio;

    audio_sample_stream_buffer #(.AUDIO_BIT_WIDTH(W), .DEPTH(16), .PREFILL(8)) dut_a (
        .clk_audio(clk_audio), .reset(reset), .in_valid(in_valid), .in_ready(ready_a),
        .in_left(in_left), .in_right(in_right), .audio_sample_word(word_a),
        .out_active(active_a), .fill_level(fill_a), .underrun_count(count_a)
    );

    audio_sample_stream_buffer #(.AUDIO_BIT_WIDTH(W), .DEPTH(16), .PREFILL(16)) dut_b (
        .clk_audio(clk_audio), .reset(reset), .in_valid(in_valid), .in_ready(ready_b),
        .in_left(in_left), .in_right(in_right), .audio_sample_word(word_b),
        .out_active(active_b), .fill_level(fill_b), .underrun_count(count_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model state
    bit          sel;
    int          m_depth, m_prefill;
    bit          m_stream;
    logic [31:0] q[$];
    logic [15:0] m_l, m_r;
    logic [15:0] m_count;
    int          seq;

    task automatic model_reset();
        q.delete();
        m_stream = 1'b0;
        m_l      = '0;
        m_r      = '0;
        m_count  = '0;
        seq      = 1;
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk_audio);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic compare_all();
        check("word_left",      32'(sel ? word_b[0] : word_a[0]), 32'(m_l));
        check("word_right",     32'(sel ? word_b[1] : word_a[1]), 32'(m_r));
        check("out_active",     32'(sel ? active_b  : active_a),  32'(m_stream));
        check("fill_level",     32'(sel ? fill_b    : fill_a),    32'(q.size()));
        check("in_ready",       32'(sel ? ready_b   : ready_a),   32'(q.size() != m_depth));
        check("underrun_count", 32'(sel ? count_b   : count_a),   32'(m_count));
    endtask

    // One clock with the source offering sample 'seq' when want is set; data held until accepted.
    task automatic cycle(input bit want);
        bit push, pop, und, stream_pre;
        int fill_pre;
        in_valid   = want;
        in_left    = 16'(seq);
        in_right   = 16'(seq + 100);
        fill_pre   = q.size();
        stream_pre = m_stream;
        push       = want && (fill_pre != m_depth);
        pop        = stream_pre && (fill_pre != 0);
        und        = stream_pre && (fill_pre == 0);
        @(posedge clk_audio);
        #1;
        if (pop) {m_l, m_r} = q.pop_front();
        if (und) begin
            m_l = '0;
            m_r = '0;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            m_stream = 1'b0;
        end else if (!stream_pre && fill_pre >= m_prefill) begin
            m_stream = 1'b1;
        end
        if (push) begin
            q.push_back({in_left, in_right});
            seq++;
        end
        compare_all();
    endtask

    typedef struct {
        bit          valid;
        logic [15:0] l, r, exp_l, exp_r;
        bit          exp_active;
        int          exp_fill;
    } vec_t;

    vec_t tbl[11];

    initial begin
        for (int k = 0; k < 8; k++)
            tbl[k] = '{1'b1, 16'(k + 1), 16'(k + 101), 16'd0, 16'd0, 1'b0, k + 1};
        tbl[8]  = '{1'b0, 16'd0, 16'd0, 16'd0, 16'd0,   1'b1, 8};
        tbl[9]  = '{1'b0, 16'd0, 16'd0, 16'd1, 16'd101, 1'b1, 7};
        tbl[10] = '{1'b0, 16'd0, 16'd0, 16'd2, 16'd102, 1'b1, 6};

        sel = 1'b0; m_depth = 16; m_prefill = 8;

        // Reset values
        do_reset(2);
        check("rst_word_left",  32'(word_a[0]), 32'd0);
        check("rst_word_right", 32'(word_a[1]), 32'd0);
        check("rst_out_active", 32'(active_a),  32'd0);
        check("rst_fill_level", 32'(fill_a),    32'd0);
        check("rst_underrun",   32'(count_a),   32'd0);
        check("rst_in_ready",   32'(ready_a),   32'd1);

        // Prefill threshold table
        for (int i = 0; i < 11; i++) begin
            in_valid = tbl[i].valid;
            in_left  = tbl[i].l;
            in_right = tbl[i].r;
            @(posedge clk_audio);
            #1;
            check("tbl_word_left",  32'(word_a[0]), 32'(tbl[i].exp_l));
            check("tbl_word_right", 32'(word_a[1]), 32'(tbl[i].exp_r));
            check("tbl_out_active", 32'(active_a),  32'(tbl[i].exp_active));
            check("tbl_fill_level", 32'(fill_a),    32'(tbl[i].exp_fill));
        end

        // Steady stream across several pointer wraps
        do_reset(1);
        repeat (80) cycle(1'b1);
        check("steady_fill_range", 32'(fill_a >= 5'd7 && fill_a <= 5'd9), 32'd1);
        check("steady_underrun",   32'(count_a), 32'd0);

        // Underrun then re-prime
        do_reset(1);
        repeat (8) cycle(1'b1);
        repeat (10) cycle(1'b0);
        check("underrun_count_1",  32'(count_a),  32'd1);
        check("underrun_inactive", 32'(active_a), 32'd0);
        repeat (7) cycle(1'b1);
        check("reprime_not_yet", 32'(active_a), 32'd0);
        repeat (12) cycle(1'b1);
        check("reprime_active", 32'(active_a), 32'd1);

        // Reset mid-stream at fill level 5
        do_reset(1);
        repeat (8) cycle(1'b1);
        repeat (4) cycle(1'b0);
        check("mid_fill_5", 32'(fill_a), 32'd5);
        reset = 1'b1;
        @(posedge clk_audio);
        #1;
        reset = 1'b0;
        model_reset();
        check("mid_rst_fill",     32'(fill_a),    32'd0);
        check("mid_rst_word_l",   32'(word_a[0]), 32'd0);
        check("mid_rst_word_r",   32'(word_a[1]), 32'd0);
        check("mid_rst_active",   32'(active_a),  32'd0);
        check("mid_rst_underrun", 32'(count_a),   32'd0);
        check("mid_rst_ready",    32'(ready_a),   32'd1);
        repeat (12) cycle(1'b1);

        // Counter saturation, starting just below the ceiling
        do_reset(1);
        force dut_a.count_q = 16'hFFFE;
        #1;
        release dut_a.count_q;
        m_count = 16'hFFFE;
        check("sat_preload", 32'(count_a), 32'hFFFE);
        repeat (3) begin
            repeat (8) cycle(1'b1);
            repeat (10) cycle(1'b0);
        end
        check("sat_sticks", 32'(count_a), 32'hFFFF);

        // Backpressure with PREFILL == DEPTH
        sel = 1'b1; m_depth = 16; m_prefill = 16;
        do_reset(1);
        repeat (16) cycle(1'b1);
        check("bp_full_fill",  32'(fill_b),  32'd16);
        check("bp_full_ready", 32'(ready_b), 32'd0);
        repeat (24) cycle(1'b1);
        repeat (30) cycle(1'b0);
        check("bp_drain_underrun", 32'(count_b), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
